// File: rtl/spi_mst_txn_ctrl_pkg.sv
// Shared types and constants for the spi_master transaction controller.
// Also holds the byte-slot and length helpers used by the packer and the unpacker.
package spi_mst_txn_ctrl_pkg;

   localparam int FIFO_W          = 128;
   localparam int CTRL_START_BIT  = 7;
   localparam int STATUS_BUSY_BIT = 7;
   localparam int LEN_W           = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FILL      = 3'd1,
      ST_START     = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_DRAIN     = 3'd4
   } state_t;

   // Byte k of a FIFO word; slot 0 occupies the top byte so it is shifted first.
   function automatic logic [7:0] fifo_byte(input logic [FIFO_W-1:0] w, input logic [3:0] k);
      return w[7'd127 - {k, 3'b000} -: 8];
   endfunction

   function automatic logic [LEN_W-1:0] calc_len(input logic [4:0] cnt, input logic mode_16b);
      logic [4:0] units;
      if (mode_16b) begin
         units = (cnt + 5'd1) >> 3'd1;
      end else begin
         units = cnt;
      end
      return LEN_W'(units - 5'd1);
   endfunction

endpackage

// File: rtl/spi_mst_txn_ctrl_if.sv
// Byte-stream and spi_master-facing signals of the transaction controller.
interface spi_mst_txn_ctrl_if;
   import spi_mst_txn_ctrl_pkg::*;

   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;
   logic [7:0]        out_data;
   logic              out_valid;
   logic              out_last;
   logic              out_ready;
   logic [FIFO_W-1:0] mst_wfifo;
   logic [7:0]        mst_ctrl;
   logic [FIFO_W-1:0] mst_rfifo;
   logic [7:0]        mst_status;
   logic              busy;
   logic              err_timeout;

   modport master (
      input  in_data, in_valid, in_last, out_ready, mst_rfifo, mst_status,
      output in_ready, out_data, out_valid, out_last, mst_wfifo, mst_ctrl, busy, err_timeout
   );

   modport slave (
      output in_data, in_valid, in_last, out_ready, mst_rfifo, mst_status,
      input  in_ready, out_data, out_valid, out_last, mst_wfifo, mst_ctrl, busy, err_timeout
   );

endinterface

// File: rtl/spi_mst_txn_ctrl_rx_unpacker.sv
// Holds the captured read FIFO and replays its first 'count' bytes as a registered
// valid/ready stream; data and valid stay put while the consumer stalls.
module spi_mst_txn_ctrl_rx_unpacker
   import spi_mst_txn_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [FIFO_W-1:0] rx_word,
   input  logic [4:0]        count,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic              out_valid,
   output logic              out_last,
   output logic              done
);
   logic [FIFO_W-1:0] shadow_r;
   logic [4:0]        idx_r;
   logic [4:0]        num_r;
   logic [4:0]        idx_inc_s;
   logic [7:0]        data_r;
   logic              valid_r;
   logic              last_r;
   logic              hs_s;

   assign hs_s      = valid_r & out_ready;
   assign done      = hs_s & last_r;
   assign idx_inc_s = idx_r + 5'd1;

   // Shadow capture and output stage; advances one byte per accepted handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_r <= '0;
         idx_r    <= 5'd0;
         num_r    <= 5'd0;
         data_r   <= 8'd0;
         valid_r  <= 1'b0;
         last_r   <= 1'b0;
      end else if (load) begin
         shadow_r <= rx_word;
         num_r    <= count;
         idx_r    <= 5'd0;
         data_r   <= fifo_byte(rx_word, 4'd0);
         valid_r  <= 1'b1;
         last_r   <= (count == 5'd1);
      end else if (hs_s) begin
         if (last_r) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            idx_r   <= 5'd0;
         end else begin
            idx_r   <= idx_inc_s;
            data_r  <= fifo_byte(shadow_r, idx_inc_s[3:0]);
            last_r  <= ((idx_inc_s + 5'd1) == num_r);
         end
      end
   end

   assign out_data  = data_r;
   assign out_valid = valid_r;
   assign out_last  = last_r;

endmodule

// File: rtl/spi_mst_txn_ctrl.sv
// Transaction controller in front of spi_master: packs a byte stream into the write FIFO,
// runs the start/busy handshake and streams the captured read FIFO back out.
module spi_mst_txn_ctrl
   import spi_mst_txn_ctrl_pkg::*;
#(
   parameter bit          MODE_16B = 1'b1,
   parameter int unsigned BUSY_TO  = 1023
) (
   input logic                clk,
   input logic                rst,
   spi_mst_txn_ctrl_if.master bus
);
   state_t            state_r;
   state_t            state_nxt_s;
   logic [4:0]        cnt_r;
   logic [4:0]        cnt_inc_s;
   logic [15:0]       to_cnt_r;
   logic [FIFO_W-1:0] wfifo_r;
   logic [7:0]        ctrl_r;
   logic              err_r;
   logic              mst_busy_s;
   logic              in_ready_s;
   logic              accept_s;
   logic              to_hit_s;
   logic              load_rx_s;
   logic              timeout_s;
   logic              drain_done_s;
   logic [7:0]        rx_data_s;
   logic              rx_valid_s;
   logic              rx_last_s;
   logic              status_unused_s;

   assign mst_busy_s      = bus.mst_status[STATUS_BUSY_BIT];
   assign status_unused_s = ^bus.mst_status[6:0];
   assign cnt_inc_s       = cnt_r + 5'd1;
   assign to_hit_s        = ((to_cnt_r + 16'd1) == 16'(BUSY_TO));

   // IDLE refuses new work while a master left running by a reset is still shifting
   assign in_ready_s = ~rst & (((state_r == ST_IDLE) & ~mst_busy_s) |
                               ((state_r == ST_FILL) & (cnt_r < 5'd16)));
   assign accept_s   = bus.in_valid & in_ready_s;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode plus one-cycle strobes for RX capture and timeout
   always_comb begin
      state_nxt_s = state_r;
      load_rx_s   = 1'b0;
      timeout_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = bus.in_last ? ST_START : ST_FILL;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (accept_s && (bus.in_last || (cnt_inc_s == 5'd16))) begin
               state_nxt_s = ST_START;
            end else begin
               state_nxt_s = ST_FILL;
            end
         end
         ST_START: begin
            if (mst_busy_s) begin
               state_nxt_s = ST_WAIT_DONE;
            end else if (to_hit_s) begin
               state_nxt_s = ST_IDLE;
               timeout_s   = 1'b1;
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_WAIT_DONE: begin
            if (!mst_busy_s) begin
               state_nxt_s = ST_DRAIN;
               load_rx_s   = 1'b1;
            end else if (to_hit_s) begin
               state_nxt_s = ST_IDLE;
               timeout_s   = 1'b1;
            end else begin
               state_nxt_s = ST_WAIT_DONE;
            end
         end
         ST_DRAIN: begin
            if (drain_done_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Packer, byte count, start/len register, timeout counter and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r    <= 5'd0;
         to_cnt_r <= 16'd0;
         wfifo_r  <= '0;
         ctrl_r   <= 8'd0;
         err_r    <= 1'b0;
      end else begin
         if (state_nxt_s != state_r) begin
            to_cnt_r <= 16'd0;
         end else if ((state_r == ST_START) || (state_r == ST_WAIT_DONE)) begin
            to_cnt_r <= to_cnt_r + 16'd1;
         end else begin
            to_cnt_r <= 16'd0;
         end

         if (accept_s) begin
            cnt_r <= cnt_inc_s;
            if (state_r == ST_IDLE) begin
               wfifo_r <= {bus.in_data, 120'd0};
            end else begin
               wfifo_r[7'd127 - {cnt_r[3:0], 3'b000} -: 8] <= bus.in_data;
            end
         end else if ((state_r != ST_IDLE) && (state_nxt_s == ST_IDLE)) begin
            cnt_r <= 5'd0;
         end

         if (accept_s && (state_nxt_s == ST_START)) begin
            ctrl_r <= {1'b1, 3'b000, calc_len(cnt_inc_s, MODE_16B)};
         end else if ((state_r == ST_START) && (state_nxt_s != ST_START)) begin
            ctrl_r[CTRL_START_BIT] <= 1'b0;
         end

         if (timeout_s) begin
            err_r <= 1'b1;
         end
      end
   end

   spi_mst_txn_ctrl_rx_unpacker u_rx (
      .clk       (clk),
      .rst       (rst),
      .load      (load_rx_s),
      .rx_word   (bus.mst_rfifo),
      .count     (cnt_r),
      .out_ready (bus.out_ready),
      .out_data  (rx_data_s),
      .out_valid (rx_valid_s),
      .out_last  (rx_last_s),
      .done      (drain_done_s)
   );

   assign bus.in_ready    = in_ready_s;
   assign bus.out_data    = rx_data_s;
   assign bus.out_valid   = rx_valid_s;
   assign bus.out_last    = rx_last_s;
   assign bus.mst_wfifo   = wfifo_r;
   assign bus.mst_ctrl    = ctrl_r;
   assign bus.busy        = (state_r != ST_IDLE);
   assign bus.err_timeout = err_r;

endmodule

// File: tb/tb_spi_mst_txn_ctrl.sv
// Directed + randomized bench for spi_mst_txn_ctrl (MODE_16B=1, BUSY_TO=15) with a
// behavioural spi_master stand-in that answers the start/busy handshake.
module tb_spi_mst_txn_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_mst_txn_ctrl_if bus ();

   spi_mst_txn_ctrl #(.MODE_16B(1'b1), .BUSY_TO(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0]   tx_q [$];
   logic [127:0] exp_wfifo;
   logic [127:0] slave_word;
   logic [127:0] seen_wfifo;
   bit           slave_dead = 1'b0;
   bit           slave_echo = 1'b0;
   int           slave_dly  = 1;
   int           slave_dur  = 3;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // spi_master stand-in: sees start, raises busy after a delay, then returns data and drops busy
   initial begin
      bus.mst_status = 8'h00;
      bus.mst_rfifo  = '0;
      forever begin
         @(negedge clk);
         if (!slave_dead && !rst && bus.mst_ctrl[7]) begin
            seen_wfifo = bus.mst_wfifo;
            repeat (slave_dly) @(negedge clk);
            bus.mst_status = {1'b1, 7'($urandom)};
            repeat (slave_dur) @(negedge clk);
            bus.mst_rfifo  = slave_echo ? seen_wfifo : slave_word;
            bus.mst_status = {1'b0, 7'($urandom)};
         end
      end
   end

   task automatic fill_rand(input int n);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
   endtask

   task automatic send_txn(input int n, input bit use_last);
      logic [127:0] w;
      bit acc;
      int guard;
      w = '0;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
         end
         acc = 1'b0;
         guard = 0;
         while (!acc && guard < 100) begin
            @(negedge clk);
            bus.in_data  = tx_q[i];
            bus.in_valid = 1'b1;
            bus.in_last  = use_last && (i == n - 1);
            #1 acc = bus.in_ready;
            guard++;
            @(posedge clk);
         end
         if (!acc) chk("in_accept_timeout", 128'(acc), 128'd1);
         w = (w << 8) | 128'(tx_q[i]);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      #1;
      w = w << (8 * (16 - n));
      exp_wfifo = w;
      chk("start_latency", 128'(bus.mst_ctrl[7]), 128'd1);
      chk("len", 128'(bus.mst_ctrl[3:0]), 128'((n + 1) / 2 - 1));
      chk("ctrl_zero_bits", 128'(bus.mst_ctrl[6:4]), 128'd0);
      chk("wfifo", bus.mst_wfifo, w);
      chk("busy_active", 128'(bus.busy), 128'd1);
      chk("no_17th_byte", 128'(bus.in_ready), 128'd0);
   endtask

   task automatic recv_txn(input int n, input int ready_mode);
      logic [127:0] rx;
      logic [7:0] held;
      bit stalled;
      int got;
      rx = slave_echo ? exp_wfifo : slave_word;
      got = 0;
      stalled = 1'b0;
      held = 8'd0;
      for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
         @(negedge clk);
         bus.out_ready = (ready_mode == 2) ? 1'b1 :
                         (ready_mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
         #1;
         chk("in_ready_busy", 128'(bus.in_ready), 128'd0);
         if (bus.out_valid) begin
            if (stalled) chk("stall_stable", 128'(bus.out_data), 128'(held));
            if (bus.out_ready) begin
               chk("rx_byte", 128'(bus.out_data), (rx >> (8 * (15 - got))) & 128'hFF);
               chk("rx_last", 128'(bus.out_last), 128'(got == n - 1));
               got++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held = bus.out_data;
            end
         end
      end
      chk("rx_count", 128'(got), 128'(n));
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      chk("rx_no_extra", 128'(bus.out_valid), 128'd0);
      chk("idle_busy", 128'(bus.busy), 128'd0);
      chk("idle_in_ready", 128'(bus.in_ready), 128'd1);
   endtask

   task automatic run_txn(input int n, input bit use_last, input int ready_mode);
      slave_dly = $urandom_range(1, 4);
      slave_dur = $urandom_range(1, 8);
      send_txn(n, use_last);
      recv_txn(n, ready_mode);
   endtask

   initial begin
      bit seen;
      bit fell;
      rst = 1'b1;
      bus.in_data = 8'd0;
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      bus.out_ready = 1'b0;
      slave_word = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
      chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
      chk("rst_out_last", 128'(bus.out_last), 128'd0);
      chk("rst_out_data", 128'(bus.out_data), 128'd0);
      chk("rst_wfifo", bus.mst_wfifo, 128'd0);
      chk("rst_ctrl", 128'(bus.mst_ctrl), 128'd0);
      chk("rst_busy", 128'(bus.busy), 128'd0);
      chk("rst_err", 128'(bus.err_timeout), 128'd0);
      rst = 1'b0;
      @(negedge clk);
      #1 chk("idle_ready_after_rst", 128'(bus.in_ready), 128'd1);

      // 16 x 0x5A, fixed read pattern
      tx_q.delete();
      repeat (16) tx_q.push_back(8'h5A);
      slave_word = {4{32'hCAFE_EFAB}};
      run_txn(16, 1'b1, 2);

      // odd count: pad byte in write FIFO, not emitted on read
      slave_echo = 1'b1;
      tx_q = {8'h11, 8'h22, 8'h33};
      run_txn(3, 1'b1, 0);
      chk("pad_word", exp_wfifo[127:96], 128'h1122_3300);

      tx_q = {8'hA5};
      run_txn(1, 1'b1, 2);
      slave_echo = 1'b0;

      // toggled out_ready during drain
      fill_rand(16);
      slave_word = {$urandom, $urandom, $urandom, $urandom};
      run_txn(16, 1'b1, 1);

      // sixteen bytes without in_last: count limit starts the transfer
      fill_rand(16);
      slave_word = {$urandom, $urandom, $urandom, $urandom};
      run_txn(16, 1'b0, 0);

      for (int t = 0; t < 6; t++) begin
         fill_rand($urandom_range(1, 16));
         slave_word = {$urandom, $urandom, $urandom, $urandom};
         run_txn(tx_q.size(), 1'b1, $urandom_range(0, 2));
      end

      // master never answers: timeout after 15 cycles in START
      slave_dead = 1'b1;
      tx_q = {8'h01, 8'h02};
      send_txn(2, 1'b1);
      repeat (14) @(negedge clk);
      #1;
      chk("to_not_yet", 128'(bus.err_timeout), 128'd0);
      chk("to_start_held", 128'(bus.mst_ctrl[7]), 128'd1);
      @(negedge clk);
      #1;
      chk("to_err", 128'(bus.err_timeout), 128'd1);
      chk("to_start_drop", 128'(bus.mst_ctrl[7]), 128'd0);
      chk("to_busy", 128'(bus.busy), 128'd0);
      chk("to_in_ready", 128'(bus.in_ready), 128'd1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1 chk("to_no_out", 128'(bus.out_valid), 128'd0);
      end
      slave_dead = 1'b0;

      // reset while waiting for the master to finish
      fill_rand(4);
      slave_word = {$urandom, $urandom, $urandom, $urandom};
      slave_dly = 1;
      slave_dur = 12;
      send_txn(4, 1'b1);
      chk("err_sticky", 128'(bus.err_timeout), 128'd1);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         #1 seen = bus.mst_status[7];
      end
      chk("master_busy_seen", 128'(seen), 128'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
      chk("mid_rst_ctrl", 128'(bus.mst_ctrl), 128'd0);
      chk("mid_rst_wfifo", bus.mst_wfifo, 128'd0);
      chk("mid_rst_busy", 128'(bus.busy), 128'd0);
      chk("mid_rst_err", 128'(bus.err_timeout), 128'd0);
      chk("mid_rst_in_ready", 128'(bus.in_ready), 128'd0);
      rst = 1'b0;
      fell = 1'b0;
      for (int c = 0; c < 40 && !fell; c++) begin
         @(negedge clk);
         #1;
         if (bus.mst_status[7]) begin
            chk("gate_in_ready", 128'(bus.in_ready), 128'd0);
            chk("gate_out_valid", 128'(bus.out_valid), 128'd0);
         end else begin
            fell = 1'b1;
         end
      end
      chk("master_finished", 128'(fell), 128'd1);
      chk("ungated_in_ready", 128'(bus.in_ready), 128'd1);

      fill_rand($urandom_range(1, 16));
      slave_word = {$urandom, $urandom, $urandom, $urandom};
      run_txn(tx_q.size(), 1'b1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
